// File: rtl/pe_group_pkg.sv
// Shared types and FP32 constants for the pe_group_mac convolution tile engine.
package pe_group_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN
    } state_e;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;

    localparam logic [31:0] QNAN = 32'h7FC00000;

endpackage

// File: rtl/fp32_mac.sv
// Combinational FP32 y = a + b*c, non-fused, round toward zero, denormals flushed to zero.
module fp32_mac
    import pe_group_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic [31:0] y
);

    logic              sp, sBig, sSmall, aBig, special, pZero, pInf;
    logic [EXP_W-1:0]  ea, eb, ec, epU, eBig, eSmall, eDiff;
    logic [MAN_W:0]    ma, mb, mc, mp, mBig, mSmall;
    logic [47:0]       prod;
    logic signed [9:0] epRaw, eRes;
    logic [53:0]       shWide;
    logic [26:0]       bigExt, smallExt, norm;
    logic [27:0]       sum;
    logic [4:0]        dCap, lz;
    logic [MAN_W-1:0]  frac;

    always_comb begin
        ea = a[MAN_W +: EXP_W];
        eb = b[MAN_W +: EXP_W];
        ec = c[MAN_W +: EXP_W];
        ma = (ea == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
        mb = (eb == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
        mc = (ec == '0) ? '0 : {1'b1, c[MAN_W-1:0]};
        special = (&ea) || (&eb) || (&ec);

        // Product: 24x24 mantissas, top 24 bits kept (truncation)
        prod  = {24'd0, mb} * {24'd0, mc};
        sp    = b[31] ^ c[31];
        epRaw = $signed({2'b00, eb}) + $signed({2'b00, ec}) - $signed(10'(BIAS))
              + $signed({9'd0, prod[47]});
        pZero = (eb == '0) || (ec == '0) || (epRaw <= 10'sd0);
        pInf  = !pZero && (epRaw >= 10'sd255);
        mp    = pZero ? '0 : 24'(prod >> (prod[47] ? 24 : 23));
        epU   = pZero ? '0 : epRaw[EXP_W-1:0];

        aBig   = {ea, ma} >= {epU, mp};
        sBig   = aBig ? a[31] : sp;
        sSmall = aBig ? sp : a[31];
        eBig   = aBig ? ea : epU;
        eSmall = aBig ? epU : ea;
        mBig   = aBig ? ma : mp;
        mSmall = aBig ? mp : ma;

        // Guard/round bits plus a sticky LSB keep truncation exact for subtraction
        eDiff    = eBig - eSmall;
        dCap     = (eDiff > 8'd30) ? 5'd30 : eDiff[4:0];
        shWide   = {mSmall, 30'd0} >> dCap;
        smallExt = {shWide[53:28], shWide[27] | (|shWide[26:0])};
        bigExt   = {mBig, 3'b000};
        sum = (sBig == sSmall) ? {1'b0, bigExt} + {1'b0, smallExt}
                               : {1'b0, bigExt} - {1'b0, smallExt};

        lz = '0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        norm = sum[26:0] << lz;
        if (sum[27]) begin
            eRes = $signed({2'b00, eBig}) + 10'sd1;
            frac = 23'(sum >> 4);
        end else begin
            eRes = $signed({2'b00, eBig}) - $signed({5'd0, lz});
            frac = 23'(norm >> 3);
        end

        if (special) begin
            y = QNAN;
        end else if (pInf) begin
            y = {sp, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ((sum == '0) || (eRes <= 10'sd0)) begin
            y = '0;
        end else if (eRes >= 10'sd255) begin
            y = {sBig, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            y = {sBig, eRes[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/pe_group_mac.sv
// FP32 1-D convolution tile: O[j] += W[k]*I[j+k] over BlockCount blocks, then streams 4 results.
// Define PE_GROUP_TEST_PORTS_EN to expose internal accumulators and counters as extra outputs.
module pe_group_mac
    import pe_group_pkg::*;
#(
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned BufferWidth     = 2,
    parameter int unsigned BufferSize      = 4,
    parameter int unsigned W_PEGroupSize   = 4,
    parameter int unsigned O_PEGroupSize   = 4,
    parameter int unsigned I_PEGroupSize   = 7,
    parameter int unsigned W_PEAddrWidth   = 2,
    parameter int unsigned O_PEAddrWidth   = 2,
    parameter int unsigned I_PEAddrWidth   = 3,
    parameter int unsigned BlockCount      = 4,
    parameter int unsigned BlockCountWidth = 3
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 W_DataInValid,
    output logic                 W_DataInRdy,
    input  logic [DataWidth-1:0] W_DataIn,
    input  logic                 I_DataInValid,
    output logic                 I_DataInRdy,
    input  logic [DataWidth-1:0] I_DataIn,
    input  logic                 O_DataInValid,
    output logic                 O_DataInRdy,
    input  logic [DataWidth-1:0] O_DataIn,
    output logic                 O_DataOutValid,
    input  logic                 O_DataOutRdy,
    output logic [DataWidth-1:0] O_DataOut
`ifdef PE_GROUP_TEST_PORTS_EN
    ,
    output logic [DataWidth-1:0]       Test_O_Data00,
    output logic [DataWidth-1:0]       Test_O_Data01,
    output logic [DataWidth-1:0]       Test_O_Data02,
    output logic [DataWidth-1:0]       Test_O_Data03,
    output logic [I_PEAddrWidth:0]     Test_I_PEAddr,
    output logic [O_PEAddrWidth:0]     Test_O_In_PEAddr,
    output logic [O_PEAddrWidth-1:0]   Test_O_Out_PEAddr,
    output logic [BlockCountWidth-1:0] Test_I_Block_Counter
`endif
);

    localparam int unsigned NumFifos = 3;
    localparam int unsigned MacWidth = W_PEAddrWidth + O_PEAddrWidth;

    // Stream index: 0 = W, 1 = I, 2 = O
    logic [NumFifos-1:0]  pushValid, fifoRdy, fifoEmpty, popReq;
    logic [DataWidth-1:0] pushData [NumFifos];
    logic [DataWidth-1:0] fifoHead [NumFifos];

    assign pushValid   = {O_DataInValid, I_DataInValid, W_DataInValid};
    assign pushData[0] = W_DataIn;
    assign pushData[1] = I_DataIn;
    assign pushData[2] = O_DataIn;
    assign W_DataInRdy = fifoRdy[0];
    assign I_DataInRdy = fifoRdy[1];
    assign O_DataInRdy = fifoRdy[2];

    for (genvar s = 0; s < NumFifos; s++) begin : gFifo
        logic [DataWidth-1:0]   mem [BufferSize];
        logic [BufferWidth-1:0] wrPtr, rdPtr;
        logic [BufferWidth:0]   count;
        logic                   push;

        assign fifoRdy[s]   = !aclr && (count != (BufferWidth+1)'(BufferSize));
        assign fifoEmpty[s] = (count == '0);
        assign fifoHead[s]  = mem[rdPtr];
        assign push         = pushValid[s] && fifoRdy[s];

        always_ff @(posedge clk) begin
            if (push) mem[wrPtr] <= pushData[s];
        end

        always_ff @(posedge clk) begin
            if (aclr) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + 1'b1;
                if (popReq[s]) rdPtr <= rdPtr + 1'b1;
                if (push && !popReq[s]) count <= count + 1'b1;
                else if (!push && popReq[s]) count <= count - 1'b1;
            end
        end
    end

    state_e                   state, stateNext;
    logic [BlockCountWidth-1:0] block;
    logic [W_PEAddrWidth:0]   wFill;
    logic [I_PEAddrWidth:0]   iFill;
    logic [O_PEAddrWidth:0]   oFill;
    logic [MacWidth-1:0]      macCnt;
    logic [O_PEAddrWidth-1:0] outAddr, outAddrNext, jIdx;
    logic [W_PEAddrWidth-1:0] kIdx;
    logic [I_PEAddrWidth-1:0] iIdx;
    logic [DataWidth-1:0]     wReg [W_PEGroupSize];
    logic [DataWidth-1:0]     iReg [I_PEGroupSize];
    logic [DataWidth-1:0]     acc  [O_PEGroupSize];
    logic [DataWidth-1:0]     macOut;
    logic                     wDone, iDone, oDone, macDone, lastBlock, outXfer, lastOut;

    assign wDone       = (wFill == (W_PEAddrWidth+1)'(W_PEGroupSize));
    assign iDone       = (iFill == (I_PEAddrWidth+1)'(I_PEGroupSize));
    assign oDone       = (oFill == (O_PEAddrWidth+1)'(O_PEGroupSize));
    assign jIdx        = macCnt[MacWidth-1 -: O_PEAddrWidth];
    assign kIdx        = macCnt[W_PEAddrWidth-1:0];
    assign iIdx        = I_PEAddrWidth'(jIdx) + I_PEAddrWidth'(kIdx);
    assign macDone     = &macCnt;
    assign lastBlock   = (block == BlockCountWidth'(BlockCount - 1));
    assign outXfer     = O_DataOutValid && O_DataOutRdy;
    assign lastOut     = (outAddr == O_PEAddrWidth'(O_PEGroupSize - 1));
    assign outAddrNext = outAddr + 1'b1;

    fp32_mac uMac (
        .a (acc[jIdx]),
        .b (wReg[kIdx]),
        .c (iReg[iIdx]),
        .y (macOut)
    );

    always_ff @(posedge clk) begin
        if (aclr) state <= LOAD;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        popReq    = '0;
        unique case (state)
            LOAD: begin
                popReq[0] = !fifoEmpty[0] && !wDone;
                popReq[1] = !fifoEmpty[1] && !iDone;
                popReq[2] = !fifoEmpty[2] && !oDone && (block == '0);
                if (wDone && iDone && (oDone || (block != '0))) stateNext = COMPUTE;
            end
            COMPUTE: if (macDone) stateNext = lastBlock ? DRAIN : LOAD;
            DRAIN:   if (outXfer && lastOut) stateNext = LOAD;
            default: stateNext = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            block          <= '0;
            wFill          <= '0;
            iFill          <= '0;
            oFill          <= '0;
            macCnt         <= '0;
            outAddr        <= '0;
            O_DataOutValid <= 1'b0;
            O_DataOut      <= '0;
            for (int i = 0; i < W_PEGroupSize; i++) wReg[i] <= '0;
            for (int i = 0; i < I_PEGroupSize; i++) iReg[i] <= '0;
            for (int i = 0; i < O_PEGroupSize; i++) acc[i] <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    macCnt <= '0;
                    if (popReq[0]) begin
                        wReg[wFill[W_PEAddrWidth-1:0]] <= fifoHead[0];
                        wFill <= wFill + 1'b1;
                    end
                    if (popReq[1]) begin
                        iReg[iFill[I_PEAddrWidth-1:0]] <= fifoHead[1];
                        iFill <= iFill + 1'b1;
                    end
                    if (popReq[2]) begin
                        acc[oFill[O_PEAddrWidth-1:0]] <= fifoHead[2];
                        oFill <= oFill + 1'b1;
                    end
                end
                COMPUTE: begin
                    acc[jIdx] <= macOut;
                    macCnt    <= macCnt + 1'b1;
                    if (macDone) begin
                        wFill <= '0;
                        iFill <= '0;
                        if (lastBlock) begin
                            // acc[0] is final here: the last MAC targets acc[3]
                            O_DataOutValid <= 1'b1;
                            O_DataOut      <= acc[0];
                            outAddr        <= '0;
                        end else begin
                            block <= block + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (outXfer) begin
                        if (lastOut) begin
                            O_DataOutValid <= 1'b0;
                            block          <= '0;
                            oFill          <= '0;
                        end else begin
                            outAddr   <= outAddrNext;
                            O_DataOut <= acc[outAddrNext];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PE_GROUP_TEST_PORTS_EN
    assign Test_O_Data00        = acc[0];
    assign Test_O_Data01        = acc[1];
    assign Test_O_Data02        = acc[2];
    assign Test_O_Data03        = acc[3];
    assign Test_I_PEAddr        = iFill;
    assign Test_O_In_PEAddr     = oFill;
    assign Test_O_Out_PEAddr    = outAddr;
    assign Test_I_Block_Counter = block;
`endif

endmodule

// File: tb/tb_pe_group_mac.sv
// Scoreboard bench for pe_group_mac: real-valued tile model, backpressure, FIFO-full, NaN, reset.
module tb_pe_group_mac;

    logic        clk = 1'b0;
    logic        aclr;
    logic        W_DataInValid, I_DataInValid, O_DataInValid;
    logic        W_DataInRdy, I_DataInRdy, O_DataInRdy;
    logic [31:0] W_DataIn, I_DataIn, O_DataIn;
    logic        O_DataOutValid, O_DataOutRdy;
    logic [31:0] O_DataOut;
`ifdef PE_GROUP_TEST_PORTS_EN
    logic [31:0] tAcc0, tAcc1, tAcc2, tAcc3;
    logic [3:0]  tIAddr;
    logic [2:0]  tOIn;
    logic [1:0]  tOOut;
    logic [2:0]  tBlock;
`endif

    always #5 clk = ~clk;

    pe_group_mac dut (
        .clk            (clk),
        .aclr           (aclr),
        .W_DataInValid  (W_DataInValid),
        .W_DataInRdy    (W_DataInRdy),
        .W_DataIn       (W_DataIn),
        .I_DataInValid  (I_DataInValid),
        .I_DataInRdy    (I_DataInRdy),
        .I_DataIn       (I_DataIn),
        .O_DataInValid  (O_DataInValid),
        .O_DataInRdy    (O_DataInRdy),
        .O_DataIn       (O_DataIn),
        .O_DataOutValid (O_DataOutValid),
        .O_DataOutRdy   (O_DataOutRdy),
        .O_DataOut      (O_DataOut)
`ifdef PE_GROUP_TEST_PORTS_EN
        ,
        .Test_O_Data00        (tAcc0),
        .Test_O_Data01        (tAcc1),
        .Test_O_Data02        (tAcc2),
        .Test_O_Data03        (tAcc3),
        .Test_I_PEAddr        (tIAddr),
        .Test_O_In_PEAddr     (tOIn),
        .Test_O_Out_PEAddr    (tOOut),
        .Test_I_Block_Counter (tBlock)
`endif
    );

    int          testsRun = 0;
    int          testsFailed = 0;
    int          outIdx = 0;
    logic [31:0] expQ[$];
    real         tileO[4];
    real         tileW[4];
    real         tileI[7];
    int          nanAt;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] toFp(input real v);
        real  m;
        int   e;
        logic s;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    function automatic logic rdyOf(input int s);
        return (s == 0) ? W_DataInRdy : (s == 1) ? I_DataInRdy : O_DataInRdy;
    endfunction

    task automatic setStream(input int s, input logic v, input logic [31:0] d);
        case (s)
            0: begin W_DataInValid = v; W_DataIn = d; end
            1: begin I_DataInValid = v; I_DataIn = d; end
            default: begin O_DataInValid = v; O_DataIn = d; end
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 after the word was taken
    task automatic pushWord(input int s, input logic [31:0] d);
        int n = 0;
        setStream(s, 1'b1, d);
        @(negedge clk);
        while (!rdyOf(s) && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (!rdyOf(s)) checkValue($sformatf("pushTimeout%0d", s), 32'(rdyOf(s)), 32'd1);
        @(posedge clk);
        #1;
        setStream(s, 1'b0, 32'h0);
    endtask

    task automatic pushExpected();
        real sum;
        for (int j = 0; j < 4; j++) begin
            sum = tileO[j];
            for (int b = 0; b < 4; b++)
                for (int k = 0; k < 4; k++) sum = sum + tileW[k] * tileI[j + k];
            if (nanAt >= j && nanAt <= j + 3) expQ.push_back(32'h7FC00000);
            else expQ.push_back(toFp(sum));
        end
    endtask

    task automatic runTile(input bit skipW0);
        pushExpected();
        for (int j = 0; j < 4; j++) pushWord(2, toFp(tileO[j]));
        for (int b = 0; b < 4; b++) begin
            if (!(skipW0 && b == 0))
                for (int k = 0; k < 4; k++) pushWord(0, toFp(tileW[k]));
            for (int i = 0; i < 7; i++)
                pushWord(1, (b == 0 && i == nanAt) ? 32'h7FC00000 : toFp(tileI[i]));
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (expQ.size() != 0) begin
            checkValue("drainTimeout", 32'(expQ.size()), 32'd0);
            expQ.delete();
        end
        @(negedge clk);
        checkValue("validDropped", 32'(O_DataOutValid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        aclr = 1'b1;
        @(negedge clk);
        checkValue("rdyForcedLow", {29'd0, W_DataInRdy, I_DataInRdy, O_DataInRdy}, 32'd0);
        @(posedge clk);
        #1;
        aclr = 1'b0;
        @(negedge clk);
        checkValue("rdyAfterReset", {29'd0, W_DataInRdy, I_DataInRdy, O_DataInRdy}, 32'd7);
        checkValue("validAfterReset", 32'(O_DataOutValid), 32'd0);
        checkValue("dataAfterReset", O_DataOut, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic setUniform();
        foreach (tileO[j]) tileO[j] = 1.0;
        foreach (tileW[k]) tileW[k] = 5.0;
        foreach (tileI[i]) tileI[i] = 20.0;
        nanAt = -1;
    endtask

    task automatic setShift();
        foreach (tileO[j]) tileO[j] = 0.0;
        foreach (tileW[k]) tileW[k] = (k == 0) ? 1.0 : 0.0;
        foreach (tileI[i]) tileI[i] = real'(i + 1);
        nanAt = -1;
    endtask

    always @(negedge clk) begin
        if (O_DataOutValid && O_DataOutRdy) begin
            if (expQ.size() == 0) checkValue("scoreboardUnderflow", 32'(expQ.size()), 32'd1);
            else checkValue($sformatf("out%0d", outIdx), O_DataOut, expQ.pop_front());
            outIdx++;
        end
    end

    initial begin
        int n;
        int accepted;
        aclr = 1'b1;
        O_DataOutRdy = 1'b1;
        setStream(0, 1'b0, 32'h0);
        setStream(1, 1'b0, 32'h0);
        setStream(2, 1'b0, 32'h0);
        doReset();

        setUniform();
        runTile(1'b0);
        waitDrain();

        setShift();
        runTile(1'b0);
        waitDrain();

        // Stalled drain; next tile's weights are pushed into the W FIFO meanwhile
        setUniform();
        O_DataOutRdy = 1'b0;
        runTile(1'b0);
        n = 0;
        while (!O_DataOutValid && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkValue("drainStarted", 32'(O_DataOutValid), 32'd1);
        @(posedge clk);
        #1;
        accepted = 0;
        W_DataInValid = 1'b1;
        W_DataIn = toFp(1.0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkValue("stallValid", 32'(O_DataOutValid), 32'd1);
            checkValue("stallData", O_DataOut, expQ[0]);
            if (W_DataInValid && W_DataInRdy) accepted++;
            @(posedge clk);
            #1;
            W_DataIn = (accepted == 0) ? toFp(1.0) : toFp(0.0);
            if (c == 5) W_DataInValid = 1'b0;
        end
        checkValue("wAccepted", 32'(accepted), 32'd4);
        @(negedge clk);
        checkValue("wRdyFull", 32'(W_DataInRdy), 32'd0);
        @(posedge clk);
        #1;
        O_DataOutRdy = 1'b1;
        waitDrain();
        n = 0;
        while (!W_DataInRdy && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkValue("wRdyReassert", 32'(W_DataInRdy), 32'd1);
        @(posedge clk);
        #1;
        setShift();
        runTile(1'b1);
        waitDrain();

        setUniform();
        nanAt = 5;
        runTile(1'b0);
        waitDrain();

        // Abort a tile in COMPUTE, then rerun it cleanly
        setUniform();
        for (int j = 0; j < 4; j++) pushWord(2, toFp(tileO[j]));
        for (int k = 0; k < 4; k++) pushWord(0, toFp(tileW[k]));
        for (int i = 0; i < 7; i++) pushWord(1, toFp(tileI[i]));
        repeat (6) @(posedge clk);
        #1;
        doReset();
        runTile(1'b0);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
